// File: rtl/multi_project_mux.sv
// multi_project_mux: Wishbone-selected pad/irq mux over NUM_PROJ designs with isolated, sequenced handover
module multi_project_mux #(
  parameter int          NUM_PROJ     = 4,
  parameter int          IO_W         = 38,
  parameter int          IRQ_W        = 3,
  parameter logic [31:0] CFG_BASE     = 32'h3000_0000,
  parameter int          GUARD_CYCLES = 16,
  parameter int          DEFAULT_PROJ = 0
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_n,
  input  logic                       wbs_cyc_i,
  input  logic                       wbs_stb_i,
  input  logic                       wbs_we_i,
  input  logic [31:0]                wbs_adr_i,
  input  logic [31:0]                wbs_dat_i,
  input  logic [3:0]                 wbs_sel_i,
  output logic                       wbs_ack_o,
  output logic [31:0]                wbs_dat_o,
  input  logic [IO_W-1:0]            io_in,
  output logic [IO_W-1:0]            io_out,
  output logic [IO_W-1:0]            io_oeb,
  output logic [IRQ_W-1:0]           user_irq,
  output logic [NUM_PROJ*IO_W-1:0]   proj_io_in,
  input  logic [NUM_PROJ*IO_W-1:0]   proj_io_out,
  input  logic [NUM_PROJ*IO_W-1:0]   proj_io_oeb,
  input  logic [NUM_PROJ*IRQ_W-1:0]  proj_irq,
  output logic [NUM_PROJ-1:0]        proj_rst_n
);
  typedef enum logic [1:0] {ACTIVE, ISOLATE, RELEASE} state_t;
  state_t state, state_n;
  logic [3:0] sel, sel_n, pend, pend_n;
  logic [15:0] guard, guard_n, cnt, cnt_n;
  logic [1:0] rel, rel_n;
  logic err, err_n, busy, hit, wr;
  logic [31:0] rd;
  logic unused_ok;
  assign unused_ok = ^{wbs_sel_i, wbs_adr_i[1:0]};
  assign busy = state != ACTIVE;
  // ack blocks a second hit in its own cycle, so held strobes never double-ack
  assign hit = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == CFG_BASE[31:4]) & ~wbs_ack_o;
  assign wr = hit & wbs_we_i;
  assign rd = wbs_adr_i[3:2] == 2'd0 ? {28'd0, sel} :
              wbs_adr_i[3:2] == 2'd1 ? {20'd0, pend, 6'd0, err, busy} :
              wbs_adr_i[3:2] == 2'd2 ? {16'd0, guard} : 32'd0;
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rel_n   = rel;
    sel_n   = sel;
    pend_n  = pend;
    err_n   = err;
    guard_n = guard;
    if (state == ISOLATE) begin
      cnt_n = cnt - 16'd1;
      if (cnt <= 16'd1) begin
        state_n = RELEASE;
        sel_n   = pend;
        rel_n   = 2'b00;
      end
    end
    if (state == RELEASE) begin
      rel_n = {rel[0], 1'b1};
      state_n = rel[0] ? ACTIVE : RELEASE;
    end
    if (wr && wbs_adr_i[3:2] == 2'd0) begin
      if (busy || wbs_dat_i >= 32'(NUM_PROJ))
        err_n = 1'b1;
      else if (wbs_dat_i[3:0] != sel) begin
        pend_n  = wbs_dat_i[3:0];
        state_n = ISOLATE;
        cnt_n   = guard;
        rel_n   = 2'b00;
      end
    end
    if (wr && wbs_adr_i[3:2] == 2'd1 && wbs_dat_i[1])
      err_n = 1'b0;
    if (wr && wbs_adr_i[3:2] == 2'd2)
      guard_n = wbs_dat_i[15:0] == 16'd0 ? 16'd1 : wbs_dat_i[15:0];
  end
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state     <= ISOLATE;
      cnt       <= 16'(GUARD_CYCLES);
      rel       <= 2'b00;
      sel       <= 4'(DEFAULT_PROJ);
      pend      <= 4'(DEFAULT_PROJ);
      err       <= 1'b0;
      guard     <= 16'(GUARD_CYCLES);
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= 32'd0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      rel       <= rel_n;
      sel       <= sel_n;
      pend      <= pend_n;
      err       <= err_n;
      guard     <= guard_n;
      wbs_ack_o <= hit;
      wbs_dat_o <= hit && !wbs_we_i ? rd : 32'd0;
    end
  end
  // pads are driven only in ACTIVE; the new design leaves reset one cycle earlier
  always_comb begin
    io_out     = '0;
    io_oeb     = '1;
    user_irq   = '0;
    proj_io_in = '0;
    proj_rst_n = '0;
    if (state == ACTIVE) begin
      io_out   = proj_io_out[int'(sel)*IO_W +: IO_W];
      io_oeb   = proj_io_oeb[int'(sel)*IO_W +: IO_W];
      user_irq = proj_irq[int'(sel)*IRQ_W +: IRQ_W];
      proj_io_in[int'(sel)*IO_W +: IO_W] = io_in;
    end
    for (int k = 0; k < NUM_PROJ; k++)
      proj_rst_n[k] = int'(sel) == k && (state == ACTIVE || (state == RELEASE && rel[0]));
  end
endmodule
